// File: rtl/aibnd_dcc_updncnt_param.sv
// Saturating up/down trim-code counter for the DCC loop with parallel load,
// scan shift on the functional clock and dither-based lock detection.
module aibnd_dcc_updncnt_param #(
  parameter int WIDTH    = 5,
  parameter int STEP     = 1,
  parameter int RST_VAL  = 0,
  parameter int LOCK_REV = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             scan_mode_n,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             en,
  input  logic             dir,
  input  logic             hold_state,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             lock
);

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MAX_CODE = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RST_CODE = WIDTH'(RST_VAL);
  localparam logic [3:0]       LOCK_LIM = 4'(LOCK_REV);

  logic [WIDTH-1:0] q_r;
  logic [3:0]       rev_cnt_r;
  logic             lock_r;
  logic             last_dir_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic [3:0]       rev_cnt_nxt_s;
  logic             lock_nxt_s;
  logic             last_dir_nxt_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] up_s;
  logic [WIDTH-1:0] dn_s;
  logic [4:0]       rev_inc_s;
  logic             rev_hit_s;

  // Saturated step candidates, computed one bit wider so the code never wraps
  always_comb begin
    sum_s     = {1'b0, q_r} + {1'b0, STEP_W};
    rev_inc_s = {1'b0, rev_cnt_r} + 5'd1;
    rev_hit_s = (rev_inc_s >= {1'b0, LOCK_LIM});
    if (sum_s > {1'b0, MAX_CODE}) begin
      up_s = MAX_CODE;
    end else begin
      up_s = sum_s[WIDTH-1:0];
    end
    if (q_r < STEP_W) begin
      dn_s = {WIDTH{1'b0}};
    end else begin
      dn_s = q_r - STEP_W;
    end
  end

  // Next-state selection: scan > load > hold > count, otherwise keep
  always_comb begin
    q_nxt_s        = q_r;
    rev_cnt_nxt_s  = rev_cnt_r;
    lock_nxt_s     = lock_r;
    last_dir_nxt_s = last_dir_r;
    if (!scan_mode_n) begin
      q_nxt_s = {q_r[WIDTH-2:0], scan_in};
    end else if (load) begin
      q_nxt_s       = load_val;
      rev_cnt_nxt_s = 4'd0;
      lock_nxt_s    = 1'b0;
    end else if (hold_state) begin
      q_nxt_s = q_r;
    end else if (en) begin
      q_nxt_s        = dir ? up_s : dn_s;
      last_dir_nxt_s = dir;
      // A saturated step still counts as a reversal for lock purposes
      if (dir != last_dir_r) begin
        if (rev_hit_s) begin
          rev_cnt_nxt_s = LOCK_LIM;
          lock_nxt_s    = 1'b1;
        end else begin
          rev_cnt_nxt_s = rev_inc_s[3:0];
          lock_nxt_s    = lock_r;
        end
      end else begin
        rev_cnt_nxt_s = 4'd0;
        lock_nxt_s    = 1'b0;
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      q_r        <= RST_CODE;
      rev_cnt_r  <= 4'd0;
      lock_r     <= 1'b0;
      last_dir_r <= 1'b1;
    end else begin
      q_r        <= q_nxt_s;
      rev_cnt_r  <= rev_cnt_nxt_s;
      lock_r     <= lock_nxt_s;
      last_dir_r <= last_dir_nxt_s;
    end
  end

  assign q        = q_r;
  assign lock     = lock_r;
  assign scan_out = q_r[WIDTH-1];
  assign full     = (q_r == MAX_CODE);
  assign empty    = (q_r == {WIDTH{1'b0}});

endmodule
